// File: rtl/fsm_cycle_seq.sv
// Per-instruction bus-cycle sequencer: walks the operand/address/memory cycles for the
// decoded addressing mode and drives address select, PC advance, read/write and completion.
module fsm_cycle_seq (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_start,
   input  logic       i_acc,
   input  logic       i_imm,
   input  logic       i_zp,
   input  logic       i_zpy,
   input  logic       i_ci,
   input  logic       i_w,
   input  logic       i_alu,
   input  logic       i_ld,
   input  logic       i_rdy,
   output logic       o_rw,
   output logic [1:0] o_addr_sel,
   output logic       o_pc_inc,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_acc_we,
   output logic [2:0] o_state
);

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StOp1  = 3'd1,
      StOp2  = 3'd2,
      StIdx  = 3'd3,
      StFix  = 3'd4,
      StMem  = 3'd5,
      StExe  = 3'd6
   } state_e;

   state_e     r_state;
   state_e     w_state_d;

   logic       r_acc, r_imm, r_zp, r_zpy, r_ci, r_w, r_alu, r_ld;

   logic       w_mode_imm;
   logic       w_mode_zpy;
   logic       w_mode_zp;
   logic       w_rw;
   logic [1:0] w_addr_sel;
   logic       w_pc_inc;
   logic       w_last;
   logic       w_illegal;
   logic       w_stall;
   logic       w_done;

   // Mode priority: ACC > IMM > ZPY > ZP > absolute.
   assign w_mode_imm = ~r_acc & r_imm;
   assign w_mode_zpy = ~r_acc & ~r_imm & r_zpy;
   assign w_mode_zp  = ~r_acc & ~r_imm & ~r_zpy & r_zp;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= StIdle;
         r_acc   <= 1'b0;
         r_imm   <= 1'b0;
         r_zp    <= 1'b0;
         r_zpy   <= 1'b0;
         r_ci    <= 1'b0;
         r_w     <= 1'b0;
         r_alu   <= 1'b0;
         r_ld    <= 1'b0;
      end else begin
         r_state <= w_state_d;
         if (r_state == StIdle && i_start) begin
            r_acc <= i_acc;
            r_imm <= i_imm;
            r_zp  <= i_zp;
            r_zpy <= i_zpy;
            r_ci  <= i_ci;
            r_w   <= i_w;
            r_alu <= i_alu;
            r_ld  <= i_ld;
         end
      end
   end

   always_comb begin
      w_state_d  = r_state;
      w_rw       = 1'b1;
      w_addr_sel = 2'b00;
      w_pc_inc   = 1'b0;
      w_last     = 1'b0;
      w_illegal  = 1'b0;
      w_stall    = 1'b0;

      case (r_state)
         StIdle: begin
            if (i_start) begin
               w_state_d = i_acc ? StExe : StOp1;
            end
         end
         StOp1: begin
            w_pc_inc = 1'b1;
            if (w_mode_imm) begin
               w_last    = 1'b1;
               w_state_d = StIdle;
            end else if (w_mode_zpy) begin
               w_state_d = StIdx;
            end else if (w_mode_zp) begin
               w_state_d = StMem;
            end else begin
               w_state_d = StOp2;
            end
         end
         StOp2: begin
            w_pc_inc  = 1'b1;
            w_state_d = r_ci ? StFix : StMem;
         end
         StIdx: begin
            w_addr_sel = 2'b01;
            w_state_d  = StMem;
         end
         StFix: begin
            w_addr_sel = 2'b10;
            w_state_d  = StMem;
         end
         StMem: begin
            w_addr_sel = (w_mode_zp | w_mode_zpy) ? 2'b01 : 2'b10;
            w_rw       = ~r_w;
            w_last     = 1'b1;
            w_state_d  = StIdle;
         end
         StExe: begin
            w_last    = 1'b1;
            w_state_d = StIdle;
         end
         default: begin
            w_illegal = 1'b1;
            w_state_d = StIdle;
         end
      endcase

      // Only read cycles wait for memory; writes and illegal codes always move on.
      w_stall = w_rw & ~i_rdy & (r_state != StIdle) & ~w_illegal;
      if (w_stall) begin
         w_state_d = r_state;
      end
   end

   // Reset masks the outputs immediately so an aborted instruction never shows DONE.
   assign w_done     = ~i_rst & w_last & ~w_stall;
   assign o_done     = w_done;
   assign o_acc_we   = w_done & (r_alu | r_ld) & ~r_w;
   assign o_pc_inc   = ~i_rst & w_pc_inc & ~w_stall;
   assign o_rw       = i_rst | w_rw;
   assign o_addr_sel = i_rst ? 2'b00 : w_addr_sel;
   assign o_busy     = ~i_rst & (r_state != StIdle);
   assign o_state    = i_rst ? 3'd0 : r_state;

endmodule

// File: tb/tb_fsm_cycle_seq.sv
// Directed bench for fsm_cycle_seq: a per-cycle vector table plus latency measurements.
module tb_fsm_cycle_seq;

   logic       clk;
   logic       rst, start, acc, imm, zp, zpy, ci, w, alu, ld, rdy;
   logic       o_rw, o_pc_inc, o_busy, o_done, o_acc_we;
   logic [1:0] o_addr_sel;
   logic [2:0] o_state;

   int checks   = 0;
   int failures = 0;

   // Input bit positions: {rst,start,acc,imm,zp,zpy,ci,w,alu,ld,rdy}
   localparam logic [10:0] InRst   = 11'h400;
   localparam logic [10:0] InStart = 11'h200;
   localparam logic [10:0] InAcc   = 11'h100;
   localparam logic [10:0] InImm   = 11'h080;
   localparam logic [10:0] InZp    = 11'h040;
   localparam logic [10:0] InZpy   = 11'h020;
   localparam logic [10:0] InCi    = 11'h010;
   localparam logic [10:0] InW     = 11'h008;
   localparam logic [10:0] InAlu   = 11'h004;
   localparam logic [10:0] InLd    = 11'h002;
   localparam logic [10:0] InRdy   = 11'h001;
   localparam logic [10:0] InNone  = 11'h000;

   typedef struct {
      string       name;
      logic [10:0] in;
      logic [9:0]  exp;
   } vec_t;

   vec_t vq[$];

   fsm_cycle_seq dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_start    (start),
      .i_acc      (acc),
      .i_imm      (imm),
      .i_zp       (zp),
      .i_zpy      (zpy),
      .i_ci       (ci),
      .i_w        (w),
      .i_alu      (alu),
      .i_ld       (ld),
      .i_rdy      (rdy),
      .o_rw       (o_rw),
      .o_addr_sel (o_addr_sel),
      .o_pc_inc   (o_pc_inc),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_acc_we   (o_acc_we),
      .o_state    (o_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected output bundle {state, rw, addr_sel, pc_inc, busy, done, acc_we}.
   function automatic logic [9:0] e(int st, int rwv, int as, int pc, int bz, int dn, int we);
      logic [9:0] r;
      r = {st[2:0], rwv[0], as[1:0], pc[0], bz[0], dn[0], we[0]};
      return r;
   endfunction

   function automatic void add(string n, logic [10:0] in, logic [9:0] ex);
      vec_t t;
      t.name = n;
      t.in   = in;
      t.exp  = ex;
      vq.push_back(t);
   endfunction

   task automatic drive(input logic [10:0] v);
      {rst, start, acc, imm, zp, zpy, ci, w, alu, ld, rdy} = v;
   endtask

   function automatic logic [9:0] outs();
      return {o_state, o_rw, o_addr_sel, o_pc_inc, o_busy, o_done, o_acc_we};
   endfunction

   task automatic latency(input string nm, input logic [10:0] fl, input int exp_n);
      int n;
      bit seen;
      @(negedge clk);
      drive(InStart | InRdy | fl);
      @(negedge clk);
      drive(InRdy);
      n    = 1;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         #1;
         if (o_done) seen = 1'b1;
         else begin
            @(negedge clk);
            n++;
         end
      end
      checks++;
      if (!seen || n != exp_n) begin
         failures++;
         $display("FAIL %s: latency got=%0d (done seen=%0d) want=%0d", nm, n, seen, exp_n);
      end
   endtask

   logic [9:0] idle_e;
   logic [9:0] got;

   initial begin
      drive(InRst | InRdy);
      idle_e = e(0, 1, 0, 0, 0, 0, 0);

      // Reset and IMM+LD
      add("rst_idle",      InRst | InRdy,                          idle_e);
      add("rst_over_start", InRst | InStart | InImm | InLd | InRdy, idle_e);
      add("idle_no_start", InRdy,                                  idle_e);
      add("imm_start",     InStart | InImm | InLd | InRdy,         idle_e);
      add("imm_op1",       InRdy,                                  e(1, 1, 0, 1, 1, 1, 1));
      add("imm_back",      InRdy,                                  idle_e);
      // Absolute, CI, ALU read with a stalled FIX
      add("abs_start",     InStart | InCi | InAlu | InRdy,         idle_e);
      add("abs_op1",       InRdy,                                  e(1, 1, 0, 1, 1, 0, 0));
      add("abs_op2",       InRdy,                                  e(2, 1, 0, 1, 1, 0, 0));
      add("abs_fix_stall", InNone,                                 e(4, 1, 2, 0, 1, 0, 0));
      add("abs_fix",       InRdy,                                  e(4, 1, 2, 0, 1, 0, 0));
      add("abs_mem",       InRdy,                                  e(5, 1, 2, 0, 1, 1, 1));
      add("abs_back",      InRdy,                                  idle_e);
      // ZPY write with RDY low
      add("zpy_start",     InStart | InZpy | InW,                  idle_e);
      add("zpy_op1_st1",   InNone,                                 e(1, 1, 0, 0, 1, 0, 0));
      add("zpy_op1_st2",   InNone,                                 e(1, 1, 0, 0, 1, 0, 0));
      add("zpy_op1",       InRdy,                                  e(1, 1, 0, 1, 1, 0, 0));
      add("zpy_idx",       InRdy,                                  e(3, 1, 1, 0, 1, 0, 0));
      add("zpy_mem_wr",    InNone,                                 e(5, 0, 1, 0, 1, 1, 0));
      add("zpy_back",      InRdy,                                  idle_e);
      // ACC beats IMM; EXE stall masks DONE
      add("acc_start",     InStart | InAcc | InImm | InAlu | InRdy, idle_e);
      add("acc_exe_stall", InNone,                                 e(6, 1, 0, 0, 1, 0, 0));
      add("acc_exe",       InRdy,                                  e(6, 1, 0, 0, 1, 1, 1));
      add("acc_back",      InRdy,                                  idle_e);
      // ZP aborted by reset in OP1
      add("zp_start",      InStart | InZp | InLd | InRdy,          idle_e);
      add("zp_op1_rst",    InRst | InRdy,                          idle_e);
      add("zp_aborted",    InRdy,                                  idle_e);
      // ZP with START ignored while busy and in the DONE cycle
      add("zp2_start",     InStart | InZp | InLd | InRdy,          idle_e);
      add("zp2_op1",       InStart | InRdy,                        e(1, 1, 0, 1, 1, 0, 0));
      add("zp2_mem",       InStart | InAcc | InRdy,                e(5, 1, 1, 0, 1, 1, 1));
      add("zp2_ignored",   InRdy,                                  idle_e);
      // Reset during a stalled MEM
      add("zp3_start",     InStart | InZp | InAlu | InRdy,         idle_e);
      add("zp3_op1",       InRdy,                                  e(1, 1, 0, 1, 1, 0, 0));
      add("zp3_mem_stall", InNone,                                 e(5, 1, 1, 0, 1, 0, 0));
      add("zp3_mem_rst",   InRst | InRdy,                          idle_e);
      add("zp3_aborted",   InRdy,                                  idle_e);
      // Absolute write; mode inputs outside IDLE must be ignored
      add("absw_start",    InStart | InW | InLd | InRdy,           idle_e);
      add("absw_op1",      InRdy | InZp | InCi | InAcc,            e(1, 1, 0, 1, 1, 0, 0));
      add("absw_op2_st",   InNone,                                 e(2, 1, 0, 0, 1, 0, 0));
      add("absw_op2",      InRdy,                                  e(2, 1, 0, 1, 1, 0, 0));
      add("absw_mem_wr",   InNone,                                 e(5, 0, 2, 0, 1, 1, 0));
      add("absw_back",     InRdy,                                  idle_e);
      // ZPY over ZP, IMM over ZPY
      add("pzy_start",     InStart | InZp | InZpy | InRdy,         idle_e);
      add("pzy_op1",       InRdy,                                  e(1, 1, 0, 1, 1, 0, 0));
      add("pzy_idx",       InRdy,                                  e(3, 1, 1, 0, 1, 0, 0));
      add("pzy_mem",       InRdy,                                  e(5, 1, 1, 0, 1, 1, 0));
      add("pzy_back",      InRdy,                                  idle_e);
      add("pim_start",     InStart | InImm | InZpy | InAlu | InRdy, idle_e);
      add("pim_op1",       InRdy,                                  e(1, 1, 0, 1, 1, 1, 1));
      add("pim_back",      InRdy,                                  idle_e);

      foreach (vq[i]) begin
         @(negedge clk);
         drive(vq[i].in);
         #1;
         got = outs();
         checks++;
         if (got !== vq[i].exp) begin
            failures++;
            $display("FAIL %s: got {st,rw,as,pc,bz,dn,we}=%b want=%b",
                     vq[i].name, got, vq[i].exp);
         end
      end

      latency("lat_acc",    InAcc, 1);
      latency("lat_imm",    InImm, 1);
      latency("lat_zp",     InZp, 2);
      latency("lat_zpy",    InZpy, 3);
      latency("lat_abs",    InNone, 3);
      latency("lat_abs_ci", InCi, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
